// File: rtl/bus_pkg.sv
// Shared definitions for the byte-bus scheduler family.
// This file holds the state encoding, the source indices and the bytes-per-word rule.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] SRC_AES = 2'd0;
    localparam logic [1:0] SRC_SHA = 2'd1;
    localparam logic [1:0] SRC_CTL = 2'd2;

    localparam int unsigned DEF_ADDRW = 24;

    function automatic int unsigned calc_nbytes(input int unsigned addrw);
        return (addrw + 8) / 8;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin picker.
// It grants the first requester after 'last' in the cyclic order 0->1->2->0.
module rr_pick3
    import bus_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] pick,
    output logic       any
);

    always_comb begin
        pick = '0;
        case (last)
            SRC_AES: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            SRC_SHA: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    assign any = |req;

endmodule

// File: rtl/bus_scheduler.sv
// Three-requester byte-bus scheduler: a round-robin grant is followed by
// LSB-first serialisation of the latched {data, address} word, then a done pulse.
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int unsigned ADDRW = DEF_ADDRW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             aes_req,
    input  logic             sha_req,
    input  logic             ctl_req,
    input  logic [ADDRW+7:0] aes_data_in,
    input  logic [ADDRW+7:0] sha_data_in,
    input  logic [ADDRW+7:0] ctl_data_in,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aes_grant,
    output logic             sha_grant,
    output logic             ctl_grant,
    output logic             aes_done,
    output logic             sha_done,
    output logic             ctl_done
);

    localparam int unsigned W         = ADDRW + 8;
    localparam int unsigned NBYTES    = calc_nbytes(ADDRW);
    localparam int unsigned CNTW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBYTES - 1);

    state_t          state, state_nxt;
    logic [1:0]      owner, last_grant, pick_idx;
    logic [W-1:0]    shift, pick_data;
    logic [CNTW-1:0] cnt;
    logic [2:0]      req, pick;
    logic            any, beat, last_beat, owned;

    assign req = {ctl_req, sha_req, aes_req};

    rr_pick3 u_pick (
        .req  (req),
        .last (last_grant),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx  = SRC_CTL;
        pick_data = ctl_data_in;
        if (pick[0]) begin
            pick_idx  = SRC_AES;
            pick_data = aes_data_in;
        end else if (pick[1]) begin
            pick_idx  = SRC_SHA;
            pick_data = sha_data_in;
        end
    end

    assign beat      = (state == SEND) && out_ready;
    assign last_beat = beat && (cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = SEND;
            SEND:    if (last_beat) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter stops at the final beat instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= SRC_AES;
            last_grant <= SRC_CTL;
            shift      <= '0;
            cnt        <= '0;
        end else begin
            if (state == IDLE && any) begin
                shift <= pick_data;
                owner <= pick_idx;
                cnt   <= '0;
            end
            if (beat) begin
                shift <= shift >> 8;
                if (last_beat) last_grant <= owner;
                else           cnt        <= cnt + CNTW'(1);
            end
        end
    end

    always_comb begin
        owned     = (state != IDLE);
        out_valid = (state == SEND);
        out_data  = shift[7:0];
        aes_grant = owned && (owner == SRC_AES);
        sha_grant = owned && (owner == SRC_SHA);
        ctl_grant = owned && (owner == SRC_CTL);
        aes_done  = (state == ACK) && (owner == SRC_AES);
        sha_done  = (state == ACK) && (owner == SRC_SHA);
        ctl_done  = (state == ACK) && (owner == SRC_CTL);
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Testbench for bus_scheduler: a transfer-level reference model is compared with the DUT every cycle.
// Directed scenarios also pin the model's grant, byte and done logs against hand values.
module tb_bus_scheduler;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aes_req = 1'b0, sha_req = 1'b0, ctl_req = 1'b0;
    logic [31:0] aes_data_in = '0, sha_data_in = '0, ctl_data_in = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        aes_grant, sha_grant, ctl_grant;
    logic        aes_done, sha_done, ctl_done;

    int n_cmp = 0;
    int n_bad = 0;

    bus_scheduler #(.ADDRW(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .aes_req     (aes_req),
        .sha_req     (sha_req),
        .ctl_req     (ctl_req),
        .aes_data_in (aes_data_in),
        .sha_data_in (sha_data_in),
        .ctl_data_in (ctl_data_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aes_grant   (aes_grant),
        .sha_grant   (sha_grant),
        .ctl_grant   (ctl_grant),
        .aes_done    (aes_done),
        .sha_done    (sha_done),
        .ctl_done    (ctl_done)
    );

    always #5 clk = ~clk;

    // Reference model: owner (-1 when free), latched word, beats accepted, ack flag, last served.
    int          m_owner, m_sent, m_last;
    logic        m_ack;
    logic [31:0] m_word;
    int          grant_log[$];
    int          byte_log[$];
    int          done_log[$];

    logic [2:0]  req_v;
    logic [31:0] data_v [3];
    assign req_v = {ctl_req, sha_req, aes_req};
    always_comb begin
        data_v[0] = aes_data_in;
        data_v[1] = sha_data_in;
        data_v[2] = ctl_data_in;
    end

    int          mdl_s;
    bit          mdl_found;
    logic [31:0] mdl_tmp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_ack   <= 1'b0;
            m_word  <= '0;
            m_sent  <= 0;
            m_last  <= 2;
        end else if (m_ack) begin
            m_ack   <= 1'b0;
            m_owner <= -1;
        end else if (m_owner < 0) begin
            mdl_found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                mdl_s = (m_last + k) % 3;
                if (!mdl_found && req_v[mdl_s]) begin
                    mdl_found = 1'b1;
                    m_owner <= mdl_s;
                    m_word  <= data_v[mdl_s];
                    m_sent  <= 0;
                    grant_log.push_back(mdl_s);
                end
            end
        end else if (out_ready) begin
            mdl_tmp = m_word >> (8 * m_sent);
            byte_log.push_back(m_owner * 256 + int'(mdl_tmp[7:0]));
            m_sent <= m_sent + 1;
            if (m_sent == NB - 1) begin
                m_ack  <= 1'b1;
                m_last <= m_owner;
                done_log.push_back(m_owner);
            end
        end
    end

    logic [14:0] exp_v, act_v;
    logic [31:0] cmp_tmp;
    always @(negedge clk) begin
        cmp_tmp = m_word >> (8 * m_sent);
        exp_v = '0;
        exp_v[14]   = (m_owner >= 0) && !m_ack;
        exp_v[13:6] = cmp_tmp[7:0];
        if (m_owner >= 0) exp_v[3 + m_owner] = 1'b1;
        if (m_ack && m_owner >= 0) exp_v[m_owner] = 1'b1;
        act_v = {out_valid, out_data, ctl_grant, sha_grant, aes_grant, ctl_done, sha_done, aes_done};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_outputs t=%0t {valid,data,grants,dones} got=%h expected=%h", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int s);
        logic [2:0] g;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            g = {ctl_grant, sha_grant, aes_grant};
            if (g[s]) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_grant src=%0d got=timeout expected=grant", s);
    endtask

    task automatic wait_done(input int s);
        logic [2:0] d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d = {ctl_done, sha_done, aes_done};
            if (d[s]) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_done src=%0d got=timeout expected=done", s);
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (grant_log.size() >= n) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_grants n=%0d got=%0d expected=%0d", n, grant_log.size(), n);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        byte_log.delete();
        done_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic chk_bytes(input string name, input int src, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        chk({name, "_count"}, byte_log.size(), NB);
        for (int i = 0; i < NB; i++)
            chk(name, (i < byte_log.size()) ? byte_log[i] : -1, src * 256 + int'(w[8*i +: 8]));
    endtask

    int exp_rr[7] = '{0, 1, 0, 1, 2, 0, 1};
    int bp_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {out_valid, out_data, aes_grant, sha_grant, ctl_grant, aes_done, sha_done, ctl_done}, 0);
        rst = 1'b0;
        clear_logs();

        // Single AES transfer
        aes_data_in = 32'hDDCCBBAA;
        aes_req = 1'b1;
        @(negedge clk);
        chk("aes_grant_latency", aes_grant, 1);
        chk("aes_first_byte", out_data, 8'hAA);
        wait_done(0);
        aes_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_bytes("single_bytes", 0, 32'hDDCCBBAA);
        chk("single_dones", done_log.size(), 1);

        // Contention from reset
        do_reset();
        aes_data_in = 32'h04030201; sha_data_in = 32'h14131211; ctl_data_in = 32'h24232221;
        aes_req = 1'b1; sha_req = 1'b1; ctl_req = 1'b1;
        wait_done(0); aes_req = 1'b0;
        wait_done(1); sha_req = 1'b0;
        wait_done(2); ctl_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("contention_grants", grant_log.size(), 3);
        for (int i = 0; i < 3; i++) chk("contention_order", (i < grant_log.size()) ? grant_log[i] : -1, i);
        chk("contention_bytes", byte_log.size(), 12);
        chk("contention_ctl_last_byte", (byte_log.size() == 12) ? byte_log[11] : -1, 2 * 256 + 8'h24);

        // Round-robin fairness with a late control request
        do_reset();
        aes_req = 1'b1; sha_req = 1'b1;
        wait_grants(3);
        ctl_req = 1'b1;
        wait_done(2); ctl_req = 1'b0;
        wait_grants(7);
        wait_done(1);
        aes_req = 1'b0; sha_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rr_grants", grant_log.size(), 7);
        for (int i = 0; i < 7; i++) chk("rr_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_rr[i]);

        // Backpressure on a SHA transfer
        do_reset();
        sha_data_in = 32'h44332211;
        sha_req = 1'b1;
        wait_grant(1);
        for (int i = 0; i < 7; i++) begin
            out_ready = bp_pat[i][0];
            @(negedge clk);
            if (i == 2) chk("bp_hold_data", out_data, 8'h22);
        end
        out_ready = 1'b1;
        chk("bp_done_now", sha_done, 1);
        sha_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_bytes("bp_bytes", 1, 32'h44332211);
        chk("bp_dones", done_log.size(), 1);

        // Reset in the middle of an AES transfer
        do_reset();
        aes_data_in = 32'hA4A3A2A1; sha_data_in = 32'hB4B3B2B1;
        aes_req = 1'b1; sha_req = 1'b1;
        wait_grant(0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("midreset_outputs", {out_valid, out_data, aes_grant, sha_grant, ctl_grant, aes_done, sha_done, ctl_done}, 0);
        chk("midreset_no_done", done_log.size(), 0);
        chk("midreset_aes_beats", byte_log.size(), 2);
        aes_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_logs();
        rst = 1'b0;
        wait_done(1);
        sha_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_bytes("midreset_sha_bytes", 1, 32'hB4B3B2B1);

        // Data changes after grant are ignored
        do_reset();
        aes_data_in = 32'h87654321;
        aes_req = 1'b1;
        wait_grant(0);
        aes_data_in = 32'hFFFFFFFF;
        wait_done(0);
        aes_req = 1'b0;
        repeat (3) @(negedge clk);
        chk_bytes("stable_bytes", 0, 32'h87654321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
